// File: rtl/ddr_pkg.sv
// Shared types for the DDR4 DIMM bank model: command/error encodings, burst descriptor, beat helpers.
// Burst timestamps are absolute cycle counts; windows are [due_cycle, due_cycle+len-1].
package ddr_pkg;

  localparam int BANK_FW = 8;
  localparam int ROW_FW  = 17;
  localparam int COL_W   = 10;
  localparam int STAMP_W = 32;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_BANK_OPEN   = 3'd1,
    ERR_BANK_CLOSED = 3'd2,
    ERR_COLLIDE     = 3'd3,
    ERR_ILLEGAL     = 3'd4
  } err_e;

  typedef struct packed {
    logic [BANK_FW-1:0] bank;
    logic [ROW_FW-1:0]  row;
    logic [COL_W-1:0]   col;
    logic               bc4;
    logic               ap;
    logic [STAMP_W-1:0] due_cycle;
  } burst_t;

  // pins = {cs_n, act_n, RAS_n, CAS_n, WE_n}
  function automatic cmd_e decode_cmd(input logic [4:0] pins);
    cmd_e c;
    c = CMD_NOP;
    if (!pins[4]) begin
      if (!pins[3]) c = CMD_ACT;
      else begin
        case (pins[2:0])
          3'b101:  c = CMD_RD;
          3'b100:  c = CMD_WR;
          3'b010:  c = CMD_PRE;
          3'b001:  c = CMD_REF;
          3'b000:  c = CMD_MRS;
          default: c = CMD_NOP;
        endcase
      end
    end
    return c;
  endfunction

  function automatic logic [STAMP_W-1:0] burst_end(input burst_t b);
    return b.due_cycle + (b.bc4 ? STAMP_W'(3) : STAMP_W'(7));
  endfunction

  function automatic logic windows_overlap(input burst_t a, input burst_t b);
    return (a.due_cycle <= burst_end(b)) && (b.due_cycle <= burst_end(a));
  endfunction

  // BC4 occupies the upper or lower half of the 8-beat word, chosen by col[2]
  function automatic logic [2:0] beat_pos(input burst_t b, input logic [2:0] idx);
    return (b.bc4 && b.col[2]) ? 3'd4 + idx : idx;
  endfunction

  function automatic logic [7:0] beat_mask(input burst_t b);
    logic [7:0] m;
    m = 8'hFF;
    if (b.bc4) m = b.col[2] ? 8'hF0 : 8'h0F;
    return m;
  endfunction

endpackage

// File: rtl/ddr_dimm_bank_model_burst_pipe.sv
// Cycle-stamped in-order burst queue with a beat counter; a burst plays when its due_cycle arrives.
// Never wraps: callers must treat full as a collision and drop the command.
module ddr_burst_pipe
  import ddr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STAMP_W-1:0] cyc,
  input  logic               push,
  input  burst_t             push_dat,
  input  burst_t             chk,
  output logic               chk_hit,
  output logic               full,
  output burst_t             head,
  output logic               beat_vld,
  output logic [2:0]         beat_idx,
  output logic               beat_last,
  output burst_t             nxt,
  output logic               nxt_due
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  burst_t             mem [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_nx, wr_ptr_nx;
  logic               active;
  logic [2:0]         cnt;
  logic               head_vld, head_due, nxt_vld;
  logic               unused_chk;

  assign rd_ptr_nx = (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
  assign wr_ptr_nx = (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
  assign full      = vld[wr_ptr];
  assign head      = mem[rd_ptr];
  assign head_vld  = vld[rd_ptr];
  assign head_due  = head_vld && !active && (head.due_cycle == cyc);
  assign beat_vld  = active || head_due;
  assign beat_idx  = active ? cnt : 3'd0;
  assign beat_last = beat_vld && (beat_idx == (head.bc4 ? 3'd3 : 3'd7));

  // While the head is mid-burst the following entry may already need its fetch
  assign nxt     = active ? mem[rd_ptr_nx] : head;
  assign nxt_vld = active ? vld[rd_ptr_nx] : head_vld;
  assign nxt_due = nxt_vld && (nxt.due_cycle == cyc + STAMP_W'(1));

  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && windows_overlap(mem[i], chk)) chk_hit = 1'b1;
  end

  assign unused_chk = ^chk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      vld    <= '0;
      active <= 1'b0;
      cnt    <= 3'd0;
    end else begin
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr_nx;
      end
      if (beat_last) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr_nx;
        active      <= 1'b0;
        cnt         <= 3'd0;
      end else if (beat_vld) begin
        active <= 1'b1;
        cnt    <= beat_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ddr_dimm_bank_model.sv
// Behavioural DDR4 DIMM: command decode, per-bank row tracking, beat-masked storage, CL/CWL burst timing.
// Read beats appear CL cycles after RD; write beats are sampled CWL cycles after WR; no backpressure.
module ddr_dimm_bank_model
  import ddr_pkg::*;
#(
  parameter int             DQ_W    = 8,
  parameter int             NUM_BG  = 4,
  parameter int             NUM_BA  = 4,
  parameter int             ROW_W   = 6,
  parameter int             CL      = 11,
  parameter int             CWL     = 9,
  parameter logic [DQ_W-1:0] RD_INIT = '0
) (
  input  logic                      CK_t,
  input  logic                      reset_n,
  input  logic                      cs_n,
  input  logic                      act_n,
  input  logic                      RAS_n_A16,
  input  logic                      CAS_n_A15,
  input  logic                      WE_n_A14,
  input  logic [$clog2(NUM_BG)-1:0] bg_addr,
  input  logic [$clog2(NUM_BA)-1:0] ba_addr,
  input  logic [13:0]               addr,
  input  logic [DQ_W-1:0]           dq_in,
  output logic [DQ_W-1:0]           dq_out,
  output logic                      rd_valid,
  output logic [NUM_BG*NUM_BA-1:0]  open_mask,
  output logic                      err,
  output logic [2:0]                err_code
);

  localparam int BANK_W = $clog2(NUM_BG) + $clog2(NUM_BA);
  localparam int NB     = NUM_BG * NUM_BA;
  localparam int DEPTH  = (CL + 8 + 7) / 8 + 1;
  localparam int IDX_W  = BANK_W + ROW_W + 7;
  localparam int WORDS  = 1 << IDX_W;

  logic [STAMP_W-1:0] cyc;
  logic [BANK_W-1:0]  bank;
  logic [16:0]        row_pins;
  cmd_e               cmd;
  logic               illegal, is_rd, collide;
  burst_t             new_b;
  logic               rd_push, wr_push;
  logic               viol;
  err_e               code, err_code_q;
  logic [NB-1:0]      act_set, pre_clr, ap_clr;
  logic [ROW_W-1:0]   row_tbl [NB];

  logic [8*DQ_W-1:0]  mem_dat [WORDS];
  logic [7:0]         mem_vld [WORDS];
  logic [DQ_W-1:0]    wbuf [8];
  logic [DQ_W-1:0]    rbuf [8];

  burst_t             rd_head, wr_head, rd_nxt, wr_nxt;
  logic               rd_hit, wr_hit, rd_full, wr_full;
  logic               rd_beat, rd_last, wr_beat, wr_last, rd_nxt_due, wr_nxt_due;
  logic [2:0]         rd_idx, wr_idx, rd_pos, wr_pos;
  logic [IDX_W-1:0]   rd_word, wr_word;
  logic [7:0]         wr_mask;
  logic               unused_bits;

  assign bank     = {bg_addr, ba_addr};
  assign row_pins = {RAS_n_A16, CAS_n_A15, WE_n_A14, addr};
  assign cmd      = decode_cmd({cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14});
  assign illegal  = (cs_n !== 1'b1) && $isunknown({cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14});
  assign is_rd    = (cmd == CMD_RD);

  always_comb begin
    new_b           = '0;
    new_b.bank      = BANK_FW'(bank);
    new_b.row       = ROW_FW'(row_tbl[bank]);
    new_b.col       = addr[9:0];
    new_b.bc4       = !addr[12];
    new_b.ap        = addr[10];
    new_b.due_cycle = cyc + (is_rd ? STAMP_W'(CL) : STAMP_W'(CWL));
  end

  // A new burst must clear every queued window in both directions
  assign collide = rd_hit || wr_hit || (is_rd ? rd_full : wr_full);

  always_comb begin
    viol    = 1'b0;
    code    = ERR_NONE;
    rd_push = 1'b0;
    wr_push = 1'b0;
    act_set = '0;
    pre_clr = '0;
    if (illegal) begin
      viol = 1'b1;
      code = ERR_ILLEGAL;
    end else begin
      case (cmd)
        CMD_ACT: begin
          if (open_mask[bank]) begin
            viol = 1'b1;
            code = ERR_BANK_OPEN;
          end else act_set[bank] = 1'b1;
        end
        CMD_RD, CMD_WR: begin
          if (!open_mask[bank]) begin
            viol = 1'b1;
            code = ERR_BANK_CLOSED;
          end else if (collide) begin
            viol = 1'b1;
            code = ERR_COLLIDE;
          end else begin
            rd_push = is_rd;
            wr_push = !is_rd;
          end
        end
        CMD_PRE: begin
          if (addr[10]) pre_clr = '1;
          else          pre_clr[bank] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ap_clr = '0;
    if (rd_last && rd_head.ap) ap_clr[rd_head.bank[BANK_W-1:0]] = 1'b1;
    if (wr_last && wr_head.ap) ap_clr[wr_head.bank[BANK_W-1:0]] = 1'b1;
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      cyc        <= '0;
      open_mask  <= '0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      cyc       <= cyc + STAMP_W'(1);
      open_mask <= (open_mask & ~(pre_clr | ap_clr)) | act_set;
      err       <= viol;
      if (viol) err_code_q <= code;
    end
  end

  assign err_code = err_code_q;

  always_ff @(posedge CK_t) begin
    if (act_set[bank]) row_tbl[bank] <= row_pins[ROW_W-1:0];
  end

  ddr_burst_pipe #(.DEPTH(DEPTH)) u_rd_pipe (
    .clk(CK_t), .rst_n(reset_n), .cyc(cyc),
    .push(rd_push), .push_dat(new_b), .chk(new_b), .chk_hit(rd_hit), .full(rd_full),
    .head(rd_head), .beat_vld(rd_beat), .beat_idx(rd_idx), .beat_last(rd_last),
    .nxt(rd_nxt), .nxt_due(rd_nxt_due)
  );

  ddr_burst_pipe #(.DEPTH(DEPTH)) u_wr_pipe (
    .clk(CK_t), .rst_n(reset_n), .cyc(cyc),
    .push(wr_push), .push_dat(new_b), .chk(new_b), .chk_hit(wr_hit), .full(wr_full),
    .head(wr_head), .beat_vld(wr_beat), .beat_idx(wr_idx), .beat_last(wr_last),
    .nxt(wr_nxt), .nxt_due(wr_nxt_due)
  );

  assign wr_pos  = beat_pos(wr_head, wr_idx);
  assign rd_pos  = beat_pos(rd_head, rd_idx);
  assign wr_mask = beat_mask(wr_head);
  assign wr_word = {wr_head.bank[BANK_W-1:0], wr_head.row[ROW_W-1:0], wr_head.col[9:3]};
  assign rd_word = {rd_nxt.bank[BANK_W-1:0], rd_nxt.row[ROW_W-1:0], rd_nxt.col[9:3]};

  // Last write beat bypasses wbuf so the whole word commits on that edge
  always_ff @(posedge CK_t) begin
    if (wr_beat) wbuf[wr_pos] <= dq_in;
    if (wr_last)
      for (int i = 0; i < 8; i++)
        if (wr_mask[i]) mem_dat[wr_word][i*DQ_W +: DQ_W] <= (3'(i) == wr_pos) ? dq_in : wbuf[i];
    if (rd_nxt_due)
      for (int i = 0; i < 8; i++)
        rbuf[i] <= mem_vld[rd_word][i] ? mem_dat[rd_word][i*DQ_W +: DQ_W] : RD_INIT;
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < WORDS; w++) mem_vld[w] <= 8'h00;
    end else if (wr_last) begin
      mem_vld[wr_word] <= mem_vld[wr_word] | wr_mask;
    end
  end

  assign rd_valid = rd_beat;
  assign dq_out   = rd_beat ? rbuf[rd_pos] : '0;

  assign unused_bits = ^{rd_head, wr_head, rd_nxt, wr_nxt, wr_nxt_due, addr[13], addr[11]};

endmodule
